bus_drive_arbiter: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 39 +++
 rtl/bus_drive_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_drive_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// ----------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the bus drive arbiters.
//   arb_state_t : arbiter state (IDLE waits for requests, GRANT holds a driver)
//   idx_width   : width of a requester index; a single requester still gets a
//                 1-bit index so that every port keeps a legal width
//   cnt_width   : width of the grant hold counter, wide enough to count up to
//                 TIMEOUT; a disabled timeout keeps a minimal 1-bit counter
// ----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational round-robin selector. Searches the request vector
// starting one position after last_grant, wrapping from NUM_REQ-1 back to 0,
// and reports the first requester found.
// Ports:
//   req        in  [NUM_REQ-1:0]  request vector
//   last_grant in  [IDX_W-1:0]    index most recently served
//   winner     out [IDX_W-1:0]    selected index (0 when nothing is found)
//   found      out                at least one request is set
// ----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int NUM_REQ = 40,
    parameter int IDX_W   = 6
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    // The scan walks from the farthest offset down to the nearest one, so the
    // last hit written is the requester closest after last_grant. This keeps
    // the loop free of early exits while still giving round-robin priority.
    always_comb begin
        int cand;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(last_grant) + off) % NUM_REQ;
            if (req[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_drive_arbiter.sv
// ----------------------------------------------------------------------------
// bus_drive_arbiter
// Round-robin arbiter feeding the shared-bus tri-state driver bank. One
// requester at a time is granted; its word is registered onto bus_din and its
// driver enable is raised. The grant is released when the consumer accepts
// the word or when the grant has been held TIMEOUT cycles without bus_ready.
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   req           in   [NUM_REQ-1:0] per-requester request, held until ack
//   req_data      in   [DATA_WIDTH-1:0] x NUM_REQ per-requester data words
//   ack           out  [NUM_REQ-1:0] acceptance pulse to the granted requester
//   enable        out  1 x NUM_REQ one-hot driver enables
//   bus_din       out  [DATA_WIDTH-1:0] registered word for the driver bank
//   bus_valid     out  a driver is enabled and bus_din is valid
//   bus_ready     in   consumer accepts the word this cycle
//   timeout_pulse out  one-cycle flag: a grant was abandoned
// ----------------------------------------------------------------------------
module bus_drive_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 40,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]    ack,
    output logic                  enable   [NUM_REQ],
    output logic [DATA_WIDTH-1:0] bus_din,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  timeout_pulse
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    // Index 0 must win first after reset, so the "previous" winner starts at
    // the top index and the search wraps around to 0.
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t       state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] pick_winner;
    logic             pick_found;
    logic             timeout_hit;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (pick_winner),
        .found      (pick_found)
    );

    // The hold limit only matters while the consumer is stalling; a ready in
    // the same cycle takes precedence and completes the transfer normally.
    always_comb begin
        timeout_hit = TIMEOUT_EN && (state == GRANT) && !bus_ready
                      && (hold_cnt == HOLD_LIMIT);
    end

    // Acceptance is combinational so the requester sees it in the same cycle
    // the consumer takes the word. It is suppressed while reset is applied.
    always_comb begin
        ack = '0;
        if ((state == GRANT) && bus_valid && bus_ready && !rst) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // Main arbitration FSM. All bus-facing outputs are registered here so the
    // driver bank never sees combinational glitches on its enables. Leaving
    // GRANT always passes through IDLE, which gives the bus one idle cycle
    // between drivers and guarantees two enables never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant_idx     <= '0;
            last_grant    <= LAST_RESET;
            hold_cnt      <= '0;
            bus_din       <= '0;
            bus_valid     <= 1'b0;
            timeout_pulse <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                enable[i] <= 1'b0;
            end
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_winner;
                        bus_din   <= req_data[pick_winner];
                        bus_valid <= 1'b1;
                        hold_cnt  <= '0;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            enable[i] <= (IDX_W'(i) == pick_winner);
                        end
                        state <= GRANT;
                    end
                end

                GRANT: begin
                    if (bus_ready || timeout_hit) begin
                        // Either way the winner moves to the back of the
                        // queue, so a stuck consumer cannot starve others.
                        last_grant    <= grant_idx;
                        bus_valid     <= 1'b0;
                        hold_cnt      <= '0;
                        timeout_pulse <= timeout_hit;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            enable[i] <= 1'b0;
                        end
                        state <= IDLE;
                    end else if (TIMEOUT_EN) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_drive_arbiter
// Self-checking bench for bus_drive_arbiter: directed scenarios followed by a
// randomized run compared cycle by cycle against a behavioural model.
// ----------------------------------------------------------------------------
module tb_bus_drive_arbiter;

    localparam int N  = 40;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [DW-1:0] req_data [N];
    logic [N-1:0]  ack;
    logic          enable [N];
    logic [DW-1:0] bus_din;
    logic          bus_valid;
    logic          bus_ready;
    logic          timeout_pulse;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: whether a driver is held, which one, for how
    // many cycles, its latched word, who was served last, and the pulse flag.
    bit            m_granted;
    int            m_idx;
    int            m_held;
    int            m_last;
    logic [DW-1:0] m_data;
    bit            m_tp;

    always #5 clk = ~clk;

    bus_drive_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .enable        (enable),
        .bus_din       (bus_din),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .timeout_pulse (timeout_pulse)
    );

    function automatic logic [N-1:0] en_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = enable[i];
        return v;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Round-robin rule: first requester strictly after 'last', wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            if (r[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        bus_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        bus_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req = '0;
        #1;
        checks++; if (en_vec() !== '0) begin errors++; $display("[TB] FAIL reset_enable got=%h exp=0", en_vec()); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", bus_valid); end
        checks++; if (bus_din !== '0) begin errors++; $display("[TB] FAIL reset_din got=%h exp=00", bus_din); end
        checks++; if (ack !== '0) begin errors++; $display("[TB] FAIL reset_ack got=%h exp=0", ack); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_tp got=%b exp=0", timeout_pulse); end
        bus_ready = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        req_data[0] = 8'hA5;
        req_data[5] = 8'h5A;
        req = onehot(0) | onehot(5);
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency got=%b exp=0", bus_valid); end
        tick();
        checks++; if (en_vec() !== onehot(0)) begin errors++; $display("[TB] FAIL basic_grant0 got=%h exp=%h", en_vec(), onehot(0)); end
        checks++; if (bus_din !== 8'hA5) begin errors++; $display("[TB] FAIL basic_din0 got=%h exp=a5", bus_din); end
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got=%b exp=1", bus_valid); end
        checks++; if (ack !== '0) begin errors++; $display("[TB] FAIL basic_noack got=%h exp=0", ack); end
        bus_ready = 1'b1;
        #1;
        checks++; if (ack !== onehot(0)) begin errors++; $display("[TB] FAIL basic_ack0 got=%h exp=%h", ack, onehot(0)); end
        tick();
        req = onehot(5);
        bus_ready = 1'b0;
        #1;
        checks++; if (en_vec() !== '0 || bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_bubble en=%h valid=%b exp=0", en_vec(), bus_valid); end
        tick();
        checks++; if (en_vec() !== onehot(5)) begin errors++; $display("[TB] FAIL basic_grant5 got=%h exp=%h", en_vec(), onehot(5)); end
        checks++; if (bus_din !== 8'h5A) begin errors++; $display("[TB] FAIL basic_din5 got=%h exp=5a", bus_din); end
        bus_ready = 1'b1;
        #1;
        checks++; if (ack !== onehot(5)) begin errors++; $display("[TB] FAIL basic_ack5 got=%h exp=%h", ack, onehot(5)); end
        tick();
        req = '0;
        bus_ready = 1'b0;
        tick();
    endtask

    // Collects grants observed through ack while requests stay held.
    task automatic collect_grants(input int want, output int seq [4], output int got);
        logic [N-1:0] prev_ack;
        logic [N-1:0] ev;
        prev_ack = '0;
        got = 0;
        for (int c = 0; c < 20 && got < want; c++) begin
            #1;
            ev = en_vec();
            checks++; if ($countones(ev) > 1) begin errors++; $display("[TB] FAIL multi_enable got=%h", ev); end
            if (ack !== '0) begin
                checks++; if (ack !== ev) begin errors++; $display("[TB] FAIL ack_vs_enable ack=%h enable=%h", ack, ev); end
                checks++; if (prev_ack !== '0) begin errors++; $display("[TB] FAIL ack_width prev=%h now=%h exp prev=0", prev_ack, ack); end
                seq[got] = first_set(ack);
                got++;
            end
            prev_ack = ack;
            tick();
        end
    endtask

    task automatic test_order();
        int seq [4];
        int got;
        int exp_seq [4];
        exp_seq = '{0, 5, 39, 0};
        do_reset();
        req = onehot(0) | onehot(5) | onehot(39);
        bus_ready = 1'b1;
        collect_grants(4, seq, got);
        checks++; if (got !== 4) begin errors++; $display("[TB] FAIL order_count got=%0d exp=4", got); end
        for (int k = 0; k < got; k++) begin
            checks++; if (seq[k] !== exp_seq[k]) begin errors++; $display("[TB] FAIL order_%0d got=%0d exp=%0d", k, seq[k], exp_seq[k]); end
        end
        req = '0;
        bus_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        int seq [4];
        int got;
        do_reset();
        req = onehot(39);
        bus_ready = 1'b1;
        tick();
        checks++; if (ack !== onehot(39)) begin errors++; $display("[TB] FAIL wrap_first got=%h exp=%h", ack, onehot(39)); end
        req = onehot(39) | onehot(2);
        tick();
        collect_grants(2, seq, got);
        checks++; if (got !== 2) begin errors++; $display("[TB] FAIL wrap_count got=%0d exp=2", got); end
        if (got == 2) begin
            checks++; if (seq[0] !== 2) begin errors++; $display("[TB] FAIL wrap_a got=%0d exp=2", seq[0]); end
            checks++; if (seq[1] !== 39) begin errors++; $display("[TB] FAIL wrap_b got=%0d exp=39", seq[1]); end
        end
        req = '0;
        bus_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data[4] = 8'h3C;
        req = onehot(4);
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) req = '0;
            req_data[4] = DW'($urandom);
            #1;
            checks++; if (en_vec() !== onehot(4)) begin errors++; $display("[TB] FAIL bp_enable_%0d got=%h exp=%h", k, en_vec(), onehot(4)); end
            checks++; if (bus_din !== 8'h3C) begin errors++; $display("[TB] FAIL bp_din_%0d got=%h exp=3c", k, bus_din); end
            checks++; if (bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_%0d got=%b exp=1", k, bus_valid); end
            checks++; if (ack !== '0) begin errors++; $display("[TB] FAIL bp_ack_%0d got=%h exp=0", k, ack); end
            tick();
        end
        bus_ready = 1'b1;
        #1;
        checks++; if (ack !== onehot(4)) begin errors++; $display("[TB] FAIL bp_ack_ready got=%h exp=%h", ack, onehot(4)); end
        tick();
        bus_ready = 1'b0;
        #1;
        checks++; if (en_vec() !== '0 || bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release en=%h valid=%b exp=0", en_vec(), bus_valid); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = onehot(3) | onehot(7);
        tick();
        for (int k = 1; k <= TO; k++) begin
            #1;
            checks++; if (en_vec() !== onehot(3) || ack !== '0 || timeout_pulse !== 1'b0) begin
                errors++; $display("[TB] FAIL to_hold_%0d en=%h ack=%h tp=%b exp en=%h ack=0 tp=0", k, en_vec(), ack, timeout_pulse, onehot(3));
            end
            tick();
        end
        #1;
        checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse got=%b exp=1", timeout_pulse); end
        checks++; if (en_vec() !== '0 || bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_release en=%h valid=%b exp=0", en_vec(), bus_valid); end
        tick();
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_width got=%b exp=0", timeout_pulse); end
        checks++; if (en_vec() !== onehot(7)) begin errors++; $display("[TB] FAIL to_next got=%h exp=%h", en_vec(), onehot(7)); end

        do_reset();
        req = onehot(3);
        tick();
        for (int k = 1; k < TO; k++) tick();
        bus_ready = 1'b1;
        #1;
        checks++; if (ack !== onehot(3)) begin errors++; $display("[TB] FAIL to_edge_ack got=%h exp=%h", ack, onehot(3)); end
        tick();
        bus_ready = 1'b0;
        req = '0;
        #1;
        checks++; if (timeout_pulse !== 1'b0 || bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_edge_release tp=%b valid=%b exp=0", timeout_pulse, bus_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data[0] = 8'h11;
        req = onehot(2);
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus_ready = 1'b1;
        #1;
        checks++; if (ack !== '0) begin errors++; $display("[TB] FAIL rstmid_ack got=%h exp=0", ack); end
        tick();
        rst = 1'b0;
        bus_ready = 1'b0;
        req = onehot(0) | onehot(1);
        #1;
        checks++; if (en_vec() !== '0 || bus_valid !== 1'b0 || bus_din !== '0 || timeout_pulse !== 1'b0 || ack !== '0) begin
            errors++; $display("[TB] FAIL rstmid_outputs en=%h valid=%b din=%h tp=%b ack=%h exp all 0", en_vec(), bus_valid, bus_din, timeout_pulse, ack);
        end
        tick();
        checks++; if (en_vec() !== onehot(0) || bus_din !== 8'h11) begin errors++; $display("[TB] FAIL rstmid_regrant en=%h din=%h exp en=%h din=11", en_vec(), bus_din, onehot(0)); end
        req = '0;
        do_reset();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_en;
        int pct;
        int w;
        do_reset();
        m_granted = 1'b0; m_idx = 0; m_held = 0; m_last = N - 1; m_data = '0; m_tp = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            pct = ((cyc / 100) % 2 == 0) ? 70 : 3;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b1;
                req_data[i] = DW'($urandom);
            end
            bus_ready = ($urandom_range(0, 99) < pct);
            rst = ($urandom_range(0, 249) == 0);
            #1;
            exp_en  = m_granted ? onehot(m_idx) : '0;
            exp_ack = (m_granted && bus_ready && !rst) ? onehot(m_idx) : '0;
            checks++; if (en_vec() !== exp_en) begin errors++; $display("[TB] FAIL rnd_enable cyc=%0d got=%h exp=%h", cyc, en_vec(), exp_en); end
            checks++; if (bus_valid !== m_granted) begin errors++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus_valid, m_granted); end
            checks++; if (ack !== exp_ack) begin errors++; $display("[TB] FAIL rnd_ack cyc=%0d got=%h exp=%h", cyc, ack, exp_ack); end
            checks++; if (timeout_pulse !== m_tp) begin errors++; $display("[TB] FAIL rnd_tp cyc=%0d got=%b exp=%b", cyc, timeout_pulse, m_tp); end
            if (m_granted) begin
                checks++; if (bus_din !== m_data) begin errors++; $display("[TB] FAIL rnd_din cyc=%0d got=%h exp=%h", cyc, bus_din, m_data); end
            end
            if (rst) begin
                m_granted = 1'b0; m_last = N - 1; m_tp = 1'b0; m_data = '0;
            end else if (!m_granted) begin
                m_tp = 1'b0;
                w = rr_pick(req, m_last);
                if (w >= 0) begin
                    m_granted = 1'b1; m_idx = w; m_data = req_data[w]; m_held = 1;
                end
            end else begin
                m_tp = 1'b0;
                if (bus_ready) begin
                    m_last = m_idx; m_granted = 1'b0;
                end else if (m_held == TO) begin
                    m_tp = 1'b1; m_last = m_idx; m_granted = 1'b0;
                end else begin
                    m_held++;
                end
            end
            tick();
            req = req & ~exp_ack;
        end
        rst = 1'b0;
        req = '0;
        bus_ready = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        bus_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i] = '0;
        test_reset();
        test_basic();
        test_order();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before tests completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
